// File: rtl/ps2_spi_slave.sv
// ps2_spi_slave: oversampled SPI mode-0 slave exchanging one status/command packet per frame.
// Optional abort counter port pair enabled by defining PS2_SPI_ABORT_CNT_EN.
module ps2_spi_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_sclk_i,
  input  logic               spi_cs_n_i,
  input  logic               spi_mosi_i,
  output logic               spi_miso_o,
  output logic               spi_miso_oe_o,
  input  logic [FRAME_W-1:0] miso_pkt_i,
  output logic               miso_ack_o,
  output logic [FRAME_W-1:0] mosi_pkt_o,
  output logic               mosi_valid_o,
  output logic               abort_o,
  output logic               busy_o
`ifdef PS2_SPI_ABORT_CNT_EN
  ,
  input  logic               abort_cnt_clr_i,
  output logic [7:0]         abort_cnt_o
`endif
);
  localparam int BW = $clog2(FRAME_W + 2);
  localparam int SW = $clog2(SYNC_STAGES + 1);
  typedef enum logic [1:0] {WAIT_CS_HIGH, IDLE, ACTIVE} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic cs_q, sclk_q, cs_s, sclk_s, mosi_s;
  logic cs_rise, cs_fall, sclk_rise, sclk_fall;
  logic [FRAME_W-1:0] tx_shreg, rx_shreg;
  logic [BW-1:0] bitcnt;
  logic [SW-1:0] settle;
  assign cs_s = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_rise = ~cs_q & cs_s;
  assign cs_fall = cs_q & ~cs_s;
  assign sclk_rise = ~sclk_q & sclk_s;
  assign sclk_fall = sclk_q & ~sclk_s;
  assign busy_o = state == ACTIVE;
  assign spi_miso_oe_o = busy_o;
  assign spi_miso_o = busy_o & tx_shreg[FRAME_W-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_q <= 1'b1;
      sclk_q <= 1'b0;
      state <= WAIT_CS_HIGH;
      settle <= '0;
      tx_shreg <= '0;
      rx_shreg <= '0;
      bitcnt <= '0;
      mosi_pkt_o <= '0;
    end else begin
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      cs_q <= cs_s;
      sclk_q <= sclk_s;
      state <= state_nxt;
      // The cs_n chain resets high, so its output is only trusted once the real pin has flushed through
      settle <= (state == WAIT_CS_HIGH && settle != SW'(SYNC_STAGES)) ? settle + 1'b1 : settle;
      if (miso_ack_o) begin
        tx_shreg <= miso_pkt_i;
        bitcnt <= '0;
      end else if (busy_o && !cs_rise) begin
        if (sclk_rise) begin
          rx_shreg <= {rx_shreg[FRAME_W-2:0], mosi_s};
          bitcnt <= (bitcnt == BW'(FRAME_W + 1)) ? bitcnt : bitcnt + 1'b1;
        end
        if (sclk_fall) tx_shreg <= {tx_shreg[FRAME_W-2:0], 1'b0};
      end
      if (mosi_valid_o) mosi_pkt_o <= rx_shreg;
    end
  end
  always_comb begin
    state_nxt = state;
    miso_ack_o = 1'b0;
    mosi_valid_o = 1'b0;
    abort_o = 1'b0;
    case (state)
      WAIT_CS_HIGH: state_nxt = (settle == SW'(SYNC_STAGES) && cs_s) ? IDLE : WAIT_CS_HIGH;
      IDLE: begin
        miso_ack_o = cs_fall;
        state_nxt = cs_fall ? ACTIVE : IDLE;
      end
      ACTIVE: begin
        mosi_valid_o = cs_rise && bitcnt == BW'(FRAME_W);
        abort_o = cs_rise && bitcnt != BW'(FRAME_W);
        state_nxt = cs_rise ? IDLE : ACTIVE;
      end
      default: state_nxt = WAIT_CS_HIGH;
    endcase
  end
`ifdef PS2_SPI_ABORT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || abort_cnt_clr_i) abort_cnt_o <= '0;
    else if (abort_o && abort_cnt_o != 8'hff) abort_cnt_o <= abort_cnt_o + 1'b1;
  end
`endif
endmodule

// File: tb/tb_ps2_spi_slave.sv
// tb_ps2_spi_slave: vector table, random frames and hand sequences against a frame-level reference model.
module tb_ps2_spi_slave;
  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic [15:0] miso_pkt = '0;
  logic miso, miso_oe, ack, valid, abort, busy;
  logic [15:0] mosi_pkt;
`ifdef PS2_SPI_ABORT_CNT_EN
  logic cnt_clr = 1'b0;
  logic [7:0] abort_cnt;
`endif
  int n_chk = 0, n_fail = 0;
  int ack_cnt = 0, val_cnt = 0, abt_cnt = 0, excl = 0;
  logic [15:0] model_pkt = '0;
  ps2_spi_slave dut (
    .clk(clk), .rst(rst), .spi_sclk_i(sclk), .spi_cs_n_i(cs_n), .spi_mosi_i(mosi),
    .spi_miso_o(miso), .spi_miso_oe_o(miso_oe), .miso_pkt_i(miso_pkt), .miso_ack_o(ack),
    .mosi_pkt_o(mosi_pkt), .mosi_valid_o(valid), .abort_o(abort), .busy_o(busy)
`ifdef PS2_SPI_ABORT_CNT_EN
    , .abort_cnt_clr_i(cnt_clr), .abort_cnt_o(abort_cnt)
`endif
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst) begin
      ack_cnt += int'(ack);
      val_cnt += int'(valid);
      abt_cnt += int'(abort);
      if ((valid && abort) || (ack && (valid || abort))) excl++;
    end
  end
  typedef struct {int n; logic [31:0] d; logic [15:0] pkt;} vec_t;
  vec_t tbl[7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // Master side: MOSI changes while SCLK is low, MISO is sampled just before each rising edge
  task automatic bits(input int n, input logic [31:0] d, output logic [31:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      mosi = d[n-1-i];
      tick(8);
      got = {got[30:0], miso};
      sclk = 1'b1;
      tick(8);
      sclk = 1'b0;
    end
  endtask
  function automatic logic [31:0] exp_miso(input logic [15:0] p, input int n);
    logic [31:0] w = {p, 16'h0};
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r = {r[30:0], w[31-i]};
    return r;
  endfunction
  task automatic run_frame(input string nm, input int n, input logic [31:0] d, input logic [15:0] pkt);
    int a0, v0, b0;
    logic [31:0] got;
    a0 = ack_cnt; v0 = val_cnt; b0 = abt_cnt;
    miso_pkt = pkt;
    cs_n = 1'b0;
    bits(n, d, got);
    tick(8);
    cs_n = 1'b1;
    tick(8);
    if (n == 16) model_pkt = d[15:0];
    chk({nm, " miso"}, got, exp_miso(pkt, n));
    chk({nm, " ack"}, ack_cnt - a0, 1);
    chk({nm, " valid"}, val_cnt - v0, (n == 16) ? 1 : 0);
    chk({nm, " abort"}, abt_cnt - b0, (n == 16) ? 0 : 1);
    chk({nm, " mosi_pkt"}, mosi_pkt, model_pkt);
  endtask
  initial begin
    logic [31:0] g1, g2;
    int a0, v0, b0, n;
    tbl[0] = '{16, 32'h0000A5C3, 16'h8E41};
    tbl[1] = '{9, 32'h000001FF, 16'h1357};
    tbl[2] = '{17, 32'h0001ACE1, 16'hFFFF};
    tbl[3] = '{0, 32'h0, 16'h2468};
    tbl[4] = '{1, 32'h1, 16'h8000};
    tbl[5] = '{15, 32'h00007FFF, 16'hAAAA};
    tbl[6] = '{16, 32'h00003C5A, 16'h0001};
    // reset held mid-frame with SCLK toggling
    cs_n = 1'b0;
    for (int i = 0; i < 4; i++) begin sclk = ~sclk; tick(4); end
    chk("rst miso", miso, 0);
    chk("rst miso_oe", miso_oe, 0);
    chk("rst ack", ack, 0);
    chk("rst mosi_pkt", mosi_pkt, 0);
    chk("rst valid", valid, 0);
    chk("rst abort", abort, 0);
    chk("rst busy", busy, 0);
`ifdef PS2_SPI_ABORT_CNT_EN
    chk("rst abort_cnt", abort_cnt, 0);
`endif
    rst = 1'b0;
    a0 = ack_cnt; v0 = val_cnt; b0 = abt_cnt;
    for (int i = 0; i < 12; i++) begin sclk = ~sclk; mosi = i[0]; tick(8); end
    chk("midframe busy", busy, 0);
    cs_n = 1'b1;
    tick(10);
    chk("midframe pulses", (ack_cnt - a0) + (val_cnt - v0) + (abt_cnt - b0), 0);
    run_frame("first", 16, 32'hA5C3, 16'h0F0F);
    foreach (tbl[i]) run_frame($sformatf("vec%0d", i), tbl[i].n, tbl[i].d, tbl[i].pkt);
    // back-to-back frames, cs_n high for a single clk
    a0 = ack_cnt; v0 = val_cnt;
    miso_pkt = 16'hC0DE;
    cs_n = 1'b0;
    bits(16, 32'h1234, g1);
    miso_pkt = 16'h5A5A;
    tick(8);
    chk("b2b busy", busy, 1);
    cs_n = 1'b1;
    tick(1);
    cs_n = 1'b0;
    bits(16, 32'hFFFF, g2);
    chk("b2b first pkt", mosi_pkt, 32'h1234);
    tick(8);
    cs_n = 1'b1;
    tick(8);
    model_pkt = 16'hFFFF;
    chk("b2b miso1", g1, exp_miso(16'hC0DE, 16));
    chk("b2b miso2", g2, exp_miso(16'h5A5A, 16));
    chk("b2b acks", ack_cnt - a0, 2);
    chk("b2b valids", val_cnt - v0, 2);
    chk("b2b second pkt", mosi_pkt, model_pkt);
    for (int i = 0; i < 20; i++) begin
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 18)) : 16;
      run_frame($sformatf("rnd%0d", i), n, $urandom, 16'($urandom));
    end
`ifdef PS2_SPI_ABORT_CNT_EN
    b0 = abt_cnt;
    for (int i = 0; i < 300; i++) begin
      cs_n = 1'b0;
      tick(6);
      cs_n = 1'b1;
      tick(6);
    end
    chk("300 aborts seen", abt_cnt - b0, 300);
    chk("abort_cnt sat", abort_cnt, 8'hff);
    cs_n = 1'b0;
    tick(6);
    cs_n = 1'b1;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        seen = abort;
      end
      chk("clr abort seen", seen, 1);
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      chk("abort_cnt clr wins", abort_cnt, 0);
    end
    tick(4);
`endif
    chk("exclusive pulses", excl, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_spi_slave.md
Name: ps2_spi_slave

Overview:
- SPI mode-0 slave front end for the PS/2 peripheral, oversampled on the system clock.
- Each 16-bit frame shifts out one MISO status packet (data[15:8], rxv, txc, rto, cto, pe, fe, oe, en) supplied by the wrapper.
- In the same frame it captures one MOSI command packet (data[15:8], txen, padding[6:3], bclr, cen, wen) and hands it to the wrapper.
- Sits directly between the external SPI pins and the PS/2 SPI wrapper that packs and decodes these packets.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on the sclk/cs_n/mosi input synchronizers (min 2).
- FRAME_W, 16, bits per SPI frame; must equal the packet width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- spi_sclk_i  in  1  SPI clock (mode 0, idles low), asynchronous.
- spi_cs_n_i  in  1  chip select, active low, asynchronous.
- spi_mosi_i  in  1  serial data from master, asynchronous.
- spi_miso_o  out  1  serial data to master.
- spi_miso_oe_o  out  1  MISO output enable (high while selected).
- miso_pkt_i  in  FRAME_W  status packet, sampled at frame start.
- miso_ack_o  out  1  1-cycle pulse: miso_pkt_i captured.
- mosi_pkt_o  out  FRAME_W  last complete command packet (held).
- mosi_valid_o  out  1  1-cycle pulse: mosi_pkt_o updated.
- abort_o  out  1  1-cycle pulse: frame ended with bit count != FRAME_W.
- busy_o  out  1  high in ACTIVE state.

Behaviour:
- Reset values: spi_miso_o=0, spi_miso_oe_o=0, miso_ack_o=0, mosi_pkt_o=0, mosi_valid_o=0, abort_o=0, busy_o=0.
- Synchronizer reset values: cs_n chain=1, sclk chain=0, mosi chain=0. FSM reset state is WAIT_CS_HIGH.
- Edge detection on the synchronized signals. Pin change to internal event latency is SYNC_STAGES+1 clk cycles.
- Timing requirements on the master: SCLK high and low phases each >= SYNC_STAGES+2 clk. CS_n fall to first SCLK rise >= SYNC_STAGES+3 clk.
- FSM states:
  - WAIT_CS_HIGH: all SPI edges ignored. Move to IDLE when synced cs_n=1. Guarantees that reset mid-frame discards the rest of that frame.
  - IDLE: on synced cs_n falling edge:
    - tx_shreg <= miso_pkt_i; miso_ack_o pulses that cycle.
    - bitcnt <= 0.
    - Move to ACTIVE.
  - ACTIVE: spi_miso_oe_o=1; spi_miso_o=tx_shreg[FRAME_W-1] (registered, MSB first).
    - SCLK rising: rx_shreg <= {rx_shreg[FRAME_W-2:0], mosi_sync}; bitcnt++ saturating at FRAME_W+1.
    - SCLK falling: tx_shreg shifts left, 0 fills the LSB. After FRAME_W bits MISO therefore drives 0.
    - On synced cs_n rising edge, return to IDLE and:
      - if bitcnt==FRAME_W: mosi_pkt_o <= rx_shreg; mosi_valid_o pulses.
      - otherwise (short, empty or overlong frame): abort_o pulses; mosi_pkt_o holds its old value.
- A cs_n rising edge in the same cycle as an SCLK edge: cs_n wins and the SCLK edge is ignored.
- SCLK edges while cs_n is high are ignored in every state.
- mosi_valid_o and abort_o are mutually exclusive; miso_ack_o is never coincident with either.
- Back-to-back frames are supported: a new cs_n falling edge is accepted in the cycle after returning to IDLE.
- No handshake back-pressure: the wrapper must consume mosi_pkt_o before the next frame ends.

Optional Feature:
- Macro PS2_SPI_ABORT_CNT_EN.
- Defined:
  - Adds output abort_cnt_o [7:0] (reset 0).
  - abort_cnt_o increments on each abort_o pulse and saturates at 255.
  - Adds input abort_cnt_clr_i: when high, clears the count the next cycle. Clear has priority over a simultaneous increment.
- Undefined: neither port exists; no counter logic is synthesized.

Test Plan:
- Reset held while cs_n=0 and SCLK toggling, then released mid-frame -> no miso_ack/mosi_valid/abort pulse until cs_n goes high. The next full frame with MOSI=0xA5C3 -> mosi_pkt_o=0xA5C3 and one mosi_valid_o pulse.
- miso_pkt_i=0x8E41 at cs_n fall, 16 SCLK cycles with period 16 clk -> master samples 0x8E41 MSB first; miso_ack_o pulses exactly once.
- Frame of 9 SCLK cycles, then cs_n rise -> abort_o pulses once; mosi_pkt_o keeps 0xA5C3.
- Frame of 17 SCLK cycles -> abort_o pulses; bits after bit 16 read as 0 on MISO.
- Two back-to-back frames (0x1234 then 0xFFFF) with 1-clk-apart cs_n edges after synchronization -> two mosi_valid_o pulses with the correct packets; miso_pkt_i re-sampled at each frame start.
- With PS2_SPI_ABORT_CNT_EN: 300 short frames -> abort_cnt_o=255. Assert abort_cnt_clr_i in the same cycle as an abort -> abort_cnt_o=0.
